// File: rtl/cla_multiword_adder_ctrl.sv
// cla_multiword_adder_ctrl
//   Adds two WIDTH-bit operands with a single 4-bit carry-look-ahead slice.
//   The slice is reused over NIB = WIDTH/4 cycles, least significant nibble
//   first. The carry between nibbles is held in a register.
//   A valid/ready handshake is used on both the request side and the result side.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request valid (a, b, cin)
//   in_ready   block idle and able to accept a request
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   out_valid  result valid (sum, cout, ovf)
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow
//   busy       operation in flight or result waiting to be taken

module carry_look_ahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Every carry is expanded directly from generate/propagate and Cin.
  // This keeps the carries from rippling inside the slice.
  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign S    = w_p ^ w_c[3:0];
  assign Cout = w_c[4];

endmodule

module cla_multiword_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_s;
  logic             w_cout;
  logic             w_last;

  // Nibble select is written as a decoded mux rather than a variable part-select.
  // This keeps the index arithmetic within the width of r_idx.
  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_nib_a = r_a[4*n +: 4];
        w_nib_b = r_b[4*n +: 4];
      end
    end
  end

  carry_look_ahead_adder u_cla (w_nib_a, w_nib_b, r_carry, w_s, w_cout);

  assign w_last = (r_idx == IDXW'(NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) r_sum[4*n +: 4] <= w_s;
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_cout;
            // The final sum MSB is bit 3 of the nibble being written in this cycle.
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_multiword_adder_ctrl.sv
// Testbench for cla_multiword_adder_ctrl with WIDTH=16.
// The expected results come from plain integer addition.

module tb_cla_multiword_adder_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int n_vec;
  int n_err;

  cla_multiword_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {cout, sum} = a + b + cin, and ovf is derived from the sign bits.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  // Waits for out_valid, checks the latency and the result, holds off for
  // `hold` cycles checking stability, then releases.
  task automatic wait_and_check(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                input logic xc, input int hold, input int exp_lat,
                                input string name);
    logic [WIDTH+1:0] r;
    int cyc;
    r = ref_add(xa, xb, xc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (exp_lat >= 0 && cyc !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    n_vec++;
    if ({ovf, cout, sum} !== r) begin
      n_err++;
      $display("FAIL %s result: got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
               name, ovf, cout, sum, r[WIDTH+1], r[WIDTH], r[WIDTH-1:0]);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, ovf, cout, sum} !== {1'b1, 1'b0, r}) begin
        n_err++;
        $display("FAIL %s hold%0d: got ov=%b ir=%b ovf=%b cout=%b sum=%h, expected ov=1 ir=0 sum=%h",
                 name, h, out_valid, in_ready, ovf, cout, sum, r[WIDTH-1:0]);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL %s release: got ir/ov/busy=%b, expected 100", name, {in_ready, out_valid, busy});
    end
    @(negedge clk) out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input int hold, input string name);
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_and_check(xa, xb, xc, hold, NIB, name);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, busy, ovf, cout, sum} !== {3'b100, 2'b00, {WIDTH{1'b0}}}) begin
      n_err++;
      $display("FAIL reset: got ir/ov/busy=%b ovf=%b cout=%b sum=%h, expected 100 0 0 0000",
               {in_ready, out_valid, busy}, ovf, cout, sum);
    end
  endtask

  task automatic test_directed;
    run_op(16'h00FF, 16'h0001, 1'b0, 0, "dir_00ff");
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "dir_ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "dir_posovf");
    run_op(16'h8000, 16'h8000, 1'b0, 0, "dir_negovf");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "dir_allones");
  endtask

  task automatic test_backpressure;
    run_op(16'h1234, 16'hEDCC, 1'b0, 5, "backpressure");
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_busy_ignore;
    @(negedge clk);
    a = 16'h000B; b = 16'h0006; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_and_check(16'h000B, 16'h0006, 1'b0, 1, -1, "busy_ignore");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL busy_ignore idle%0d: got ov/busy=%b, expected 00", i, {out_valid, busy});
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, busy, ovf, cout, sum} !== {3'b100, 2'b00, {WIDTH{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_mid: got ir/ov/busy=%b ovf=%b cout=%b sum=%h, expected 100 0 0 0000",
               {in_ready, out_valid, busy}, ovf, cout, sum);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid no_pulse: got out_valid=%b, expected 0", out_valid);
      end
    end
    run_op(16'h0005, 16'h0003, 1'b1, 0, "after_reset");
  endtask

  // Requests and results are held continuously, so successive results are spaced by NIB+2 cycles.
  task automatic test_back_to_back;
    logic [WIDTH+1:0] r;
    int last, seen;
    r = ref_add(16'h4321, 16'h0FEF, 1'b1);
    @(negedge clk);
    a = 16'h4321; b = 16'h0FEF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    last = -1; seen = 0;
    for (int t = 0; t < 4 * (NIB + 2) + 2; t++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n_vec++;
        if ({ovf, cout, sum} !== r) begin
          n_err++;
          $display("FAIL b2b result: got %b/%b/%h, expected %b/%b/%h",
                   ovf, cout, sum, r[WIDTH+1], r[WIDTH], r[WIDTH-1:0]);
        end
        if (last >= 0) begin
          n_vec++;
          if (t - last !== NIB + 2) begin
            n_err++;
            $display("FAIL b2b interval: got %0d, expected %0d", t - last, NIB + 2);
          end
        end
        last = t; seen++;
      end
    end
    n_vec++;
    if (seen < 3) begin
      n_err++;
      $display("FAIL b2b count: got %0d results, expected at least 3", seen);
    end
    @(negedge clk) in_valid = 1'b0;
    repeat (NIB + 3) @(posedge clk);
    @(negedge clk) out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_directed;
    test_backpressure;
    test_busy_ignore;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
